// File: rtl/axis_stream_checker.sv
// axis_stream_checker
//   AXI4-Stream integrity and bandwidth checker. After a start pulse it checks
//   one or more packets against an incrementing data pattern. It counts beats,
//   idle-ready (miss) cycles, data errors and packet-length errors, and it
//   captures the first data mismatch.
//   decouple_streams=1: the checker sinks the stream itself.
//   decouple_streams=0: it monitors a pass-through path to m_*.
//   Optional feature macro: AXIS_STREAM_CHECKER_STALL_RUN_EN adds max_stall_run,
//   the longest run of consecutive miss cycles.

module axis_stream_checker #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 32,
  parameter int STEP          = 1,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  output logic                     idle,
  input  logic [PKT_CNT_WIDTH-1:0] num_packets,
  input  logic [COUNT_WIDTH-1:0]   pkt_len,
  input  logic [DATA_WIDTH-1:0]    seed,
  input  logic                     decouple_streams,
  input  logic                     s_tvalid,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [DATA_WIDTH-1:0]    m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [COUNT_WIDTH-1:0]   beat_count,
  output logic [COUNT_WIDTH-1:0]   miss_count,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic [COUNT_WIDTH-1:0]   length_error_count,
  output logic [PKT_CNT_WIDTH-1:0] packet_count,
  output logic                     first_err_valid,
  output logic [COUNT_WIDTH-1:0]   first_err_beat,
  output logic [DATA_WIDTH-1:0]    first_err_data
`ifdef AXIS_STREAM_CHECKER_STALL_RUN_EN
  ,
  output logic [COUNT_WIDTH-1:0]   max_stall_run
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

  // Saturating increment shared by every statistic counter.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t                   r_state;
  logic [PKT_CNT_WIDTH-1:0] r_num_packets;
  logic [COUNT_WIDTH-1:0]   r_pkt_len;
  logic [DATA_WIDTH-1:0]    r_seed;
  logic [DATA_WIDTH-1:0]    r_expected;
  logic [COUNT_WIDTH-1:0]   r_pkt_beats;
  logic [COUNT_WIDTH-1:0]   r_beat_count;
  logic [COUNT_WIDTH-1:0]   r_miss_count;
  logic [COUNT_WIDTH-1:0]   r_error_count;
  logic [COUNT_WIDTH-1:0]   r_length_error_count;
  logic [PKT_CNT_WIDTH-1:0] r_packet_count;
  logic                     r_first_err_valid;
  logic [COUNT_WIDTH-1:0]   r_first_err_beat;
  logic [DATA_WIDTH-1:0]    r_first_err_data;

  logic                     w_run;
  logic                     w_count_en;
  logic                     w_accept;
  logic                     w_miss;
  logic                     w_data_err;
  logic [COUNT_WIDTH-1:0]   w_pkt_total;
  logic [PKT_CNT_WIDTH:0]   w_pkt_next;
  logic                     w_final_pkt;

  assign w_run = (r_state == ST_RUN);

  // Combinational handshake. In pass-through mode the checker only observes the
  // transfer. In decoupled mode it accepts every beat for the whole run.
  assign s_tready = decouple_streams ? w_run : m_tready;
  assign m_tvalid = decouple_streams ? 1'b0 : s_tvalid;
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;

  // A start or stop pulse takes priority in its cycle. Nothing is counted on
  // that edge, so the counters hold on stop and start cleanly on start.
  assign w_count_en  = w_run & ~start & ~stop;
  assign w_accept    = w_count_en & s_tvalid & s_tready;
  assign w_miss      = w_count_en & s_tready & ~s_tvalid;
  assign w_data_err  = (s_tdata != r_expected);
  assign w_pkt_total = sat_inc(r_pkt_beats);
  // The packet count is widened by one bit so that the compare against the
  // latched target never wraps.
  assign w_pkt_next  = {1'b0, r_packet_count} + 1'b1;
  assign w_final_pkt = (w_pkt_next == {1'b0, r_num_packets});

  // Run-control FSM and all statistics; every output is registered here.
  // NOTE: sequential state uses non-blocking (<=) so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the latched run configuration is reset too; no storage here is left uninitialised.
    if (reset) begin
      r_state              <= ST_IDLE;
      r_num_packets        <= '0;
      r_pkt_len            <= '0;
      r_seed               <= '0;
      r_expected           <= '0;
      r_pkt_beats          <= '0;
      r_beat_count         <= '0;
      r_miss_count         <= '0;
      r_error_count        <= '0;
      r_length_error_count <= '0;
      r_packet_count       <= '0;
      r_first_err_valid    <= 1'b0;
      r_first_err_beat     <= '0;
      r_first_err_data     <= '0;
    end else if (start) begin
      r_state              <= ST_RUN;
      r_num_packets        <= (num_packets == '0) ? PKT_CNT_WIDTH'(1) : num_packets;
      r_pkt_len            <= pkt_len;
      r_seed               <= seed;
      r_expected           <= seed;
      r_pkt_beats          <= '0;
      r_beat_count         <= '0;
      r_miss_count         <= '0;
      r_error_count        <= '0;
      r_length_error_count <= '0;
      r_packet_count       <= '0;
      r_first_err_valid    <= 1'b0;
      r_first_err_beat     <= '0;
      r_first_err_data     <= '0;
    end else if (stop) begin
      r_state <= ST_IDLE;
    end else begin
      if (w_miss) begin
        r_miss_count <= sat_inc(r_miss_count);
      end
      if (w_accept) begin
        r_beat_count <= sat_inc(r_beat_count);
        if (w_data_err) begin
          r_error_count <= sat_inc(r_error_count);
          if (!r_first_err_valid) begin
            r_first_err_valid <= 1'b1;
            r_first_err_beat  <= r_beat_count;
            r_first_err_data  <= s_tdata;
          end
        end
        // The expected value resyncs to the received data, so a dropped
        // sample costs exactly one error.
        r_expected <= s_tlast ? r_seed : s_tdata + STEP_W;
        if (s_tlast) begin
          r_pkt_beats <= '0;
          if (!(&r_packet_count)) begin
            r_packet_count <= w_pkt_next[PKT_CNT_WIDTH-1:0];
          end
          if ((r_pkt_len != '0) && (w_pkt_total != r_pkt_len)) begin
            r_length_error_count <= sat_inc(r_length_error_count);
          end
          if (w_final_pkt) begin
            r_state <= ST_IDLE;
          end
        end else begin
          r_pkt_beats <= w_pkt_total;
        end
      end
    end
  end

  assign idle               = ~w_run;
  assign beat_count         = r_beat_count;
  assign miss_count         = r_miss_count;
  assign error_count        = r_error_count;
  assign length_error_count = r_length_error_count;
  assign packet_count       = r_packet_count;
  assign first_err_valid    = r_first_err_valid;
  assign first_err_beat     = r_first_err_beat;
  assign first_err_data     = r_first_err_data;

`ifdef AXIS_STREAM_CHECKER_STALL_RUN_EN
  logic [COUNT_WIDTH-1:0] r_cur_stall;
  logic [COUNT_WIDTH-1:0] r_max_stall;
  logic [COUNT_WIDTH-1:0] w_cur_stall_inc;

  assign w_cur_stall_inc = sat_inc(r_cur_stall);

  // Track the current miss run and keep the longest one seen in this run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_stall <= '0;
      r_max_stall <= '0;
    end else if (start) begin
      r_cur_stall <= '0;
      r_max_stall <= '0;
    end else if (w_accept) begin
      r_cur_stall <= '0;
    end else if (w_miss) begin
      r_cur_stall <= w_cur_stall_inc;
      if (w_cur_stall_inc > r_max_stall) begin
        r_max_stall <= w_cur_stall_inc;
      end
    end
  end

  assign max_stall_run = r_max_stall;
`endif

endmodule

// File: tb/tb_axis_stream_checker.sv
// tb_axis_stream_checker
//   Scoreboard bench for axis_stream_checker (DATA_WIDTH=8 so that wrap-around
//   is easy to reach). The driver records the beats it handed over and the miss
//   cycles it created. A reference model turns that record into expected
//   statistics, which go into a queue. A negedge monitor pops each entry and
//   compares it, and it also checks the combinational handshake every cycle.

module tb_axis_stream_checker;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic          idle;
  logic [PW-1:0] num_packets;
  logic [CW-1:0] pkt_len;
  logic [DW-1:0] seed;
  logic          decouple_streams;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;
  logic [CW-1:0] beat_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] error_count;
  logic [CW-1:0] length_error_count;
  logic [PW-1:0] packet_count;
  logic          first_err_valid;
  logic [CW-1:0] first_err_beat;
  logic [DW-1:0] first_err_data;

  always #5 clk = ~clk;

  axis_stream_checker #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .STEP(1), .PKT_CNT_WIDTH(PW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .idle(idle),
    .num_packets(num_packets), .pkt_len(pkt_len), .seed(seed),
    .decouple_streams(decouple_streams),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .beat_count(beat_count), .miss_count(miss_count), .error_count(error_count),
    .length_error_count(length_error_count), .packet_count(packet_count),
    .first_err_valid(first_err_valid), .first_err_beat(first_err_beat),
    .first_err_data(first_err_data)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    string         name;
    logic          idle;
    logic [CW-1:0] beat;
    logic [CW-1:0] miss;
    logic [CW-1:0] err;
    logic [CW-1:0] lerr;
    logic [PW-1:0] pkts;
    logic          fev;
    logic [CW-1:0] fbeat;
    logic [DW-1:0] fdata;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  mon_e;
  beat_t none_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    tb_running = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: statistics of one run, taken from the ordered list of
  // accepted beats and the number of miss cycles the driver created.
  function automatic exp_t model(input string name, input logic [DW-1:0] sd, input int plen,
                                 input beat_t acc[$], input int misses, input logic idle_exp);
    exp_t          e;
    logic [DW-1:0] want;
    int            pb;
    e.name = name;  e.idle = idle_exp;  e.beat = '0;  e.err = '0;  e.lerr = '0;
    e.pkts = '0;    e.fev = 1'b0;       e.fbeat = '0; e.fdata = '0;
    e.miss = CW'(misses);
    want = sd;
    pb   = 0;
    foreach (acc[i]) begin
      if (acc[i].data != want) begin
        e.err++;
        if (!e.fev) begin
          e.fev = 1'b1;  e.fbeat = CW'(i);  e.fdata = acc[i].data;
        end
      end
      e.beat++;
      pb++;
      if (acc[i].last) begin
        want = sd;
        e.pkts++;
        if (plen != 0 && pb != plen) e.lerr++;
        pb = 0;
      end else begin
        want = acc[i].data + DW'(1);
      end
    end
    return e;
  endfunction

  // Monitor: checks the handshake rules on every cycle and drains the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      check("hs/s_tready", s_tready, decouple_streams ? tb_running : m_tready);
      check("hs/m_tvalid", m_tvalid, decouple_streams ? 1'b0 : s_tvalid);
      check("hs/m_tdata",  {m_tlast, m_tdata}, {s_tlast, s_tdata});
      check("hs/idle",     idle, !tb_running);
    end
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.name, "/idle"},   idle,               mon_e.idle);
      check({mon_e.name, "/beat"},   beat_count,         mon_e.beat);
      check({mon_e.name, "/miss"},   miss_count,         mon_e.miss);
      check({mon_e.name, "/err"},    error_count,        mon_e.err);
      check({mon_e.name, "/lenerr"}, length_error_count, mon_e.lerr);
      check({mon_e.name, "/pkts"},   packet_count,       mon_e.pkts);
      check({mon_e.name, "/fev"},    first_err_valid,    mon_e.fev);
      check({mon_e.name, "/fbeat"},  first_err_beat,     mon_e.fbeat);
      check({mon_e.name, "/fdata"},  first_err_data,     mon_e.fdata);
    end
  end

  // The ending argument selects how the run stops:
  //   0 = the final tlast ends the run
  //   1 = a stop pulse arrives in place of the final beat
  //   2 = start is raised together with the final tlast
  //   3 = reset is asserted in place of the final beat
  task automatic run_test(input string name, input bit dec, input logic [DW-1:0] sd,
                          input int npk, input int plen, input beat_t bq[$],
                          input int gap_pct, input int rdy_mode, input int ending);
    beat_t acc[$];
    int    misses = 0;
    int    idx    = 0;
    int    cyc    = 0;
    int    n_send;
    bit    held   = 1'b0;
    bit    v;
    bit    r;
    n_send = (ending == 0) ? bq.size() : bq.size() - 1;
    decouple_streams = dec;  seed = sd;
    num_packets = PW'(npk);  pkt_len = CW'(plen);
    start = 1'b1;  s_tvalid = 1'b0;  m_tready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;  tb_running = 1'b1;
    while (idx < n_send) begin
      if (cyc > 4000) begin
        check({name, "/cycle_budget"}, 1, 0);
        break;
      end
      v = held || ($urandom_range(99) >= gap_pct);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'(($urandom_range(1)));
      endcase
      m_tready = r;  s_tvalid = v;
      s_tdata  = bq[idx].data;  s_tlast = bq[idx].last;
      if (dec) r = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (v && r) begin
        acc.push_back(bq[idx]);
        idx++;
        held = 1'b0;
      end else begin
        held = v;
        if (r && !v) misses++;
      end
    end
    s_tvalid = 1'b0;  s_tlast = 1'b0;  m_tready = 1'b0;
    case (ending)
      0: begin
        tb_running = 1'b0;
        sb_q.push_back(model(name, sd, plen, acc, misses, 1'b1));
      end
      1: begin
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;  tb_running = 1'b0;
        sb_q.push_back(model({name, "/stop"}, sd, plen, acc, misses, 1'b1));
      end
      2: begin
        start = 1'b1;  s_tvalid = 1'b1;  m_tready = 1'b1;
        s_tdata = bq[bq.size()-1].data;  s_tlast = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;  s_tvalid = 1'b0;  s_tlast = 1'b0;  m_tready = 1'b0;
        sb_q.push_back(model({name, "/restart"}, sd, plen, none_q, 0, 1'b0));
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;  tb_running = 1'b0;
        sb_q.push_back(model({name, "/stop"}, sd, plen, none_q, 0, 1'b1));
      end
      default: begin
        reset = 1'b1;  tb_running = 1'b0;
        sb_q.push_back(model({name, "/async_reset"}, sd, plen, none_q, 0, 1'b1));
        @(negedge clk); #1;
        reset = 1'b0;
      end
    endcase
    @(posedge clk); #1;
  endtask

  // Builds packets of an incrementing pattern from the seed, with optional
  // length jitter and random corruption.
  task automatic build(input logic [DW-1:0] sd, input int npk, input int plen,
                       input int corrupt_pct, output beat_t q[$]);
    int    np;
    int    len;
    beat_t b;
    q  = {};
    np = (npk == 0) ? 1 : npk;
    for (int p = 0; p < np; p++) begin
      if (plen == 0) len = $urandom_range(1, 5);
      else if ($urandom_range(3) == 0) len = plen + $urandom_range(2) - 1;
      else len = plen;
      if (len < 1) len = 1;
      for (int k = 0; k < len; k++) begin
        b.data = sd + DW'(k);
        if ($urandom_range(99) < corrupt_pct) b.data = DW'($urandom);
        b.last = (k == len - 1);
        q.push_back(b);
      end
    end
  endtask

  // Turns a list of data values into a single packet with tlast on the final value.
  function automatic void mk(input int vals[$], output beat_t q[$]);
    beat_t b;
    q = {};
    foreach (vals[i]) begin
      b.data = DW'(vals[i]);
      b.last = (i == vals.size() - 1);
      q.push_back(b);
    end
  endfunction

  initial begin
    beat_t q[$];
    beat_t t[$];
    int    vals[$];
    // NOTE: bench drives inputs with blocking assignments #1 after the edge, clear of the sampling edge.
    reset = 1'b1;  start = 1'b0;  stop = 1'b0;  decouple_streams = 1'b1;
    num_packets = '0;  pkt_len = '0;  seed = '0;
    s_tvalid = 1'b0;  s_tdata = '0;  s_tlast = 1'b0;  m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(model("reset_state", '0, 0, none_q, 0, 1'b1));
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Continuous 16-beat packet.
    vals = {};
    for (int i = 0; i < 16; i++) vals.push_back(i);
    mk(vals, q);
    run_test("cont16", 1'b1, 8'h00, 1, 16, q, 0, 0, 0);

    // A skipped sample costs exactly one error.
    vals = {5, 6, 8, 9};
    mk(vals, q);
    run_test("skip", 1'b1, 8'h05, 1, 4, q, 0, 0, 0);

    // Pass-through with a toggling downstream ready.
    vals = {0, 1, 2, 3, 4, 5, 6, 7};
    mk(vals, q);
    run_test("passthru", 1'b0, 8'h00, 1, 8, q, 0, 1, 0);

    // Three packets of 4, 3 and 4 beats.
    vals = {0, 1, 2, 3};  mk(vals, q);
    vals = {0, 1, 2};     mk(vals, t);  foreach (t[i]) q.push_back(t[i]);
    vals = {0, 1, 2, 3};  mk(vals, t);  foreach (t[i]) q.push_back(t[i]);
    run_test("multi", 1'b1, 8'h00, 3, 4, q, 0, 0, 0);

    // Data wrap-around.
    vals = {8'hFE, 8'hFF, 8'h00, 8'h01};
    mk(vals, q);
    run_test("wrap", 1'b1, 8'hFE, 1, 4, q, 0, 0, 0);

    // Reset mid-run, start on the final tlast, and stop mid-run.
    vals = {3, 4, 5, 6, 7};
    mk(vals, q);
    run_test("rst_mid", 1'b1, 8'h03, 1, 5, q, 20, 0, 3);
    run_test("start_last", 1'b1, 8'h03, 1, 5, q, 20, 0, 2);
    run_test("stop_mid", 1'b1, 8'h03, 1, 5, q, 20, 0, 1);

    // Randomised runs.
    for (int n = 0; n < 14; n++) begin
      logic [DW-1:0] sd;
      int            npk;
      int            plen;
      sd   = DW'($urandom);
      npk  = $urandom_range(3);
      plen = $urandom_range(5);
      build(sd, npk, plen, 15, q);
      run_test($sformatf("rnd%0d", n), 1'($urandom_range(1)), sd, npk, plen, q,
               25, 2, (n % 4 == 3) ? 1 : ((n % 4 == 1) ? 2 : 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
